// File: rtl/scroll_sequencer.sv
// Sequencer for the rotating display pattern shifter: latches a pattern, strobes a
// one-cycle load, then issues rotate strobes at a programmable rate (one-shot or continuous).
module scroll_sequencer #(
  parameter int N     = 8,
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [N-1:0]     pattern_in,
  input  logic [DIV_W-1:0] rate,
  input  logic [CNT_W-1:0] steps,
  output logic             sh_load,
  output logic [N-1:0]     sh_data,
  output logic             sh_shift,
  output logic [CNT_W-1:0] step_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     data_q, data_d;
  logic [DIV_W-1:0] rate_q, rate_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             tick;

  assign cnt_inc = cnt_q + 1'b1;
  // A shift fires only on an unpaused, un-stopped RUN cycle at the end of the period.
  assign tick    = (state_q == S_RUN) && !stop && !pause && (presc_q == rate_q);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rate_d  = rate_q;
    steps_d = steps_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          data_d  = pattern_in;
          rate_d  = rate;
          steps_d = steps;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        presc_d = '0;
        state_d = stop ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (!pause) begin
          if (presc_q == rate_q) begin
            presc_d = '0;
            cnt_d   = cnt_inc;
            if ((steps_q != '0) && (cnt_inc == steps_q)) state_d = S_DONE;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      rate_q  <= '0;
      steps_q <= '0;
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rate_q  <= rate_d;
      steps_q <= steps_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sh_load    = (state_q == S_LOAD);
  assign sh_shift   = tick;
  assign busy       = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign sh_data    = data_q;
  assign step_count = cnt_q;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Bench for scroll_sequencer: a cycle table for the one-shot flow, directed corner
// sequences, and randomized one-shot runs against a schedule computed from the rules.
module tb_scroll_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, pause;
  logic [7:0]  pattern_in;
  logic [15:0] rate;
  logic [7:0]  steps;
  logic        sh_load, sh_shift, busy, done;
  logic [7:0]  sh_data, step_count;

  int n_tests = 0;
  int n_fail  = 0;

  scroll_sequencer #(.N(8), .DIV_W(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .pattern_in(pattern_in), .rate(rate), .steps(steps),
    .sh_load(sh_load), .sh_data(sh_data), .sh_shift(sh_shift),
    .step_count(step_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, sp, pz;
    logic [7:0] pat;
    logic [15:0] rt;
    logic [7:0] stp;
    logic       ld, sh, bz, dn;
    logic [7:0] cnt, dat;
  } vec_t;

  vec_t tbl[18];

  task automatic set_in(input logic st, sp, pz, input logic [7:0] pat,
                        input logic [15:0] rt, input logic [7:0] stp);
    start = st; stop = sp; pause = pz; pattern_in = pat; rate = rt; steps = stp;
  endtask

  task automatic cmp(input string nm, input logic [19:0] act, input logic [19:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {ld,sh,bz,dn,cnt,dat}=%05h want %05h", nm, act, exp);
    end
  endtask

  // Inputs already applied for this cycle; check at negedge, then advance past the edge.
  task automatic step_chk(input string nm, input logic ld, sh, bz, dn,
                          input logic [7:0] cnt, dat);
    @(negedge clk);
    cmp(nm, {sh_load, sh_shift, busy, done, step_count, sh_data}, {ld, sh, bz, dn, cnt, dat});
    @(posedge clk); #1;
  endtask

  task automatic rand_trial(input int id);
    logic [7:0] pat;
    int r, st, u, k, done_at, ns;
    bit pz[200];
    int shift_at[$];
    pat = 8'($urandom);
    r   = $urandom_range(0, 4);
    st  = $urandom_range(1, 5);
    for (int i = 0; i < 200; i++) pz[i] = ($urandom_range(0, 3) == 0);
    // Shift on every (rate+1)-th unpaused RUN cycle; RUN starts in cycle 2.
    u = 0; k = 2;
    while (shift_at.size() < st && k < 195) begin
      if (!pz[k]) begin
        if (u % (r + 1) == r) shift_at.push_back(k);
        u++;
      end
      k++;
    end
    done_at = shift_at[shift_at.size()-1] + 1;
    set_in(1'b1, 1'b0, 1'b0, pat, 16'(r), 8'(st));
    step_chk($sformatf("rand%0d_idle", id), 0, 0, 0, 0, step_count, sh_data);
    for (int c = 1; c <= done_at + 1; c++) begin
      ns = 0;
      foreach (shift_at[j]) if (shift_at[j] < c) ns++;
      set_in((c < done_at) ? 1'($urandom) : 1'b0, 1'b0, pz[c],
             8'($urandom), 16'($urandom), 8'($urandom));
      step_chk($sformatf("rand%0d_c%0d", id, c), c == 1, c inside {shift_at},
               (c >= 1) && (c < done_at), c == done_at, 8'(ns), pat);
    end
  endtask

  initial begin
    // start stop pause pat rate steps | ld sh bz dn cnt dat
    tbl[0]  = '{1,1,0,8'h55,16'd2,8'd4, 0,0,0,0,8'd0,8'h00};
    tbl[1]  = '{0,0,0,8'h55,16'd2,8'd4, 0,0,0,0,8'd0,8'h00};
    tbl[2]  = '{1,0,0,8'h81,16'd2,8'd4, 0,0,0,0,8'd0,8'h00};
    tbl[3]  = '{1,0,0,8'h3C,16'd7,8'd9, 1,0,1,0,8'd0,8'h81};
    tbl[4]  = '{0,0,0,8'h3C,16'd7,8'd9, 0,0,1,0,8'd0,8'h81};
    tbl[5]  = '{0,0,0,8'h3C,16'd7,8'd9, 0,0,1,0,8'd0,8'h81};
    tbl[6]  = '{1,0,0,8'hFF,16'd0,8'd1, 0,1,1,0,8'd0,8'h81};
    tbl[7]  = '{0,0,0,8'hFF,16'd0,8'd1, 0,0,1,0,8'd1,8'h81};
    tbl[8]  = '{0,0,0,8'hFF,16'd0,8'd1, 0,0,1,0,8'd1,8'h81};
    tbl[9]  = '{0,0,0,8'hFF,16'd0,8'd1, 0,1,1,0,8'd1,8'h81};
    tbl[10] = '{0,0,0,8'hFF,16'd0,8'd1, 0,0,1,0,8'd2,8'h81};
    tbl[11] = '{0,0,0,8'hFF,16'd0,8'd1, 0,0,1,0,8'd2,8'h81};
    tbl[12] = '{0,0,0,8'hFF,16'd0,8'd1, 0,1,1,0,8'd2,8'h81};
    tbl[13] = '{0,0,0,8'hFF,16'd0,8'd1, 0,0,1,0,8'd3,8'h81};
    tbl[14] = '{0,0,0,8'hFF,16'd0,8'd1, 0,0,1,0,8'd3,8'h81};
    tbl[15] = '{0,0,0,8'hFF,16'd0,8'd1, 0,1,1,0,8'd3,8'h81};
    tbl[16] = '{0,0,0,8'hFF,16'd0,8'd1, 0,0,0,1,8'd4,8'h81};
    tbl[17] = '{0,0,0,8'hFF,16'd0,8'd1, 0,0,0,0,8'd4,8'h81};

    reset = 1'b1;
    set_in(0, 0, 0, 8'h00, 16'd0, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("reset_state", {sh_load, sh_shift, busy, done, step_count, sh_data}, 20'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // One-shot cycle table, including start+stop in IDLE and start during LOAD/RUN.
    for (int i = 0; i < 18; i++) begin
      set_in(tbl[i].st, tbl[i].sp, tbl[i].pz, tbl[i].pat, tbl[i].rt, tbl[i].stp);
      step_chk($sformatf("table_row%0d", i), tbl[i].ld, tbl[i].sh, tbl[i].bz,
               tbl[i].dn, tbl[i].cnt, tbl[i].dat);
    end

    // Reset asserted mid-RUN, in a shift cycle, clears outputs immediately.
    set_in(1, 0, 0, 8'h5A, 16'd3, 8'd0);
    step_chk("rst_seq_idle", 0, 0, 0, 0, 8'd4, 8'h81);
    set_in(0, 0, 0, 8'h00, 16'd0, 8'd0);
    step_chk("rst_seq_load", 1, 0, 1, 0, 8'd0, 8'h5A);
    for (int c = 2; c < 5; c++) step_chk("rst_seq_run", 0, 0, 1, 0, 8'd0, 8'h5A);
    #1;
    cmp("rst_pre_shift", {sh_load, sh_shift, busy, done, step_count, sh_data},
        {4'b0110, 8'd0, 8'h5A});
    reset = 1'b1; #1;
    cmp("rst_async", {sh_load, sh_shift, busy, done, step_count, sh_data}, 20'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) step_chk("rst_after_idle", 0, 0, 0, 0, 8'd0, 8'h00);

    // Continuous mode, rate 0: shift every RUN cycle, count wraps, then stop.
    set_in(1, 0, 0, 8'hC3, 16'd0, 8'd0);
    step_chk("cont_idle", 0, 0, 0, 0, 8'd0, 8'h00);
    set_in(0, 0, 0, 8'h00, 16'd0, 8'd0);
    step_chk("cont_load", 1, 0, 1, 0, 8'd0, 8'hC3);
    for (int c = 2; c <= 260; c++) step_chk($sformatf("cont_c%0d", c), 0, 1, 1, 0, 8'(c - 2), 8'hC3);
    set_in(0, 1, 0, 8'h00, 16'd0, 8'd0);
    step_chk("cont_stop", 0, 0, 1, 0, 8'd3, 8'hC3);
    set_in(0, 0, 0, 8'h00, 16'd0, 8'd0);
    step_chk("cont_after_stop", 0, 0, 0, 0, 8'd3, 8'hC3);

    // Pause held 5 cycles from prescaler==rate delays the shift by exactly 5.
    set_in(1, 0, 0, 8'hA5, 16'd3, 8'd2);
    step_chk("pz_idle", 0, 0, 0, 0, 8'd3, 8'hC3);
    set_in(0, 0, 0, 8'h00, 16'd0, 8'd0);
    step_chk("pz_load", 1, 0, 1, 0, 8'd0, 8'hA5);
    for (int c = 2; c <= 4; c++) step_chk("pz_run", 0, 0, 1, 0, 8'd0, 8'hA5);
    pause = 1'b1;
    for (int c = 5; c <= 9; c++) step_chk($sformatf("pz_hold%0d", c), 0, 0, 1, 0, 8'd0, 8'hA5);
    pause = 1'b0;
    step_chk("pz_shift1", 0, 1, 1, 0, 8'd0, 8'hA5);
    for (int c = 11; c <= 13; c++) step_chk("pz_run2", 0, 0, 1, 0, 8'd1, 8'hA5);
    step_chk("pz_shift2", 0, 1, 1, 0, 8'd1, 8'hA5);
    step_chk("pz_done", 0, 0, 0, 1, 8'd2, 8'hA5);
    step_chk("pz_idle_after", 0, 0, 0, 0, 8'd2, 8'hA5);

    // Stop coinciding with a tick suppresses the shift.
    set_in(1, 0, 0, 8'h0F, 16'd1, 8'd0);
    step_chk("st_idle", 0, 0, 0, 0, 8'd2, 8'hA5);
    set_in(0, 0, 0, 8'h00, 16'd0, 8'd0);
    step_chk("st_load", 1, 0, 1, 0, 8'd0, 8'h0F);
    step_chk("st_p0", 0, 0, 1, 0, 8'd0, 8'h0F);
    stop = 1'b1;
    step_chk("st_tick_stop", 0, 0, 1, 0, 8'd0, 8'h0F);
    stop = 1'b0;
    step_chk("st_after", 0, 0, 0, 0, 8'd0, 8'h0F);

    // Stop during LOAD: load strobe still issued, then IDLE.
    set_in(1, 0, 0, 8'hE7, 16'd0, 8'd3);
    step_chk("sl_idle", 0, 0, 0, 0, 8'd0, 8'h0F);
    set_in(0, 1, 0, 8'h00, 16'd0, 8'd0);
    step_chk("sl_load_stop", 1, 0, 1, 0, 8'd0, 8'hE7);
    stop = 1'b0;
    step_chk("sl_after", 0, 0, 0, 0, 8'd0, 8'hE7);

    for (int t = 0; t < 20; t++) rand_trial(t);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

endmodule
